rocketcpu_knob_tracker: RTL



---
 rtl/rocketcpu_knob_tracker_pkg.sv | 13 +
 rtl/rocketcpu_knob_tracker_cmp.sv | 23 ++
 rtl/rocketcpu_knob_tracker.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rocketcpu_knob_tracker_pkg.sv
// Shared constants for the pot-sample hysteresis tracker: register word indices and defaults.
package rocketcpu_knob_tracker_pkg;

  localparam int DW_DEFAULT   = 12;
  localparam int HYST_DEFAULT = 16;

  // Word indices (byte address bits [5:2])
  localparam logic [3:0] REG_VAL0   = 4'd0;
  localparam logic [3:0] REG_PEND   = 4'd8;
  localparam logic [3:0] REG_IRQEN  = 4'd9;
  localparam logic [3:0] REG_THRESH = 4'd10;

endpackage

// File: rtl/rocketcpu_knob_tracker_cmp.sv
// Absolute difference between a new sample and the stored value, compared
// strictly against the hysteresis threshold. Purely combinational.
module rocketcpu_knob_cmp
  import rocketcpu_knob_tracker_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0] i_new,
  input  logic [DW-1:0] i_old,
  input  logic [DW-1:0] i_thresh,
  output logic          o_update
);

  logic [DW:0] diff;

  // One extra bit keeps the subtraction free of wrap for any operand pair
  always_comb begin
    if (i_new >= i_old) diff = {1'b0, i_new} - {1'b0, i_old};
    else                diff = {1'b0, i_old} - {1'b0, i_new};
    o_update = (diff > {1'b0, i_thresh});
  end

endmodule

// File: rtl/rocketcpu_knob_tracker.sv
// Per-channel hysteresis on ADC samples, a Wishbone register view
// of the debounced values, a change-pending mask and a level interrupt.
module rocketcpu_knob_tracker
  import rocketcpu_knob_tracker_pkg::*;
#(
  parameter int NCH      = 8,
  parameter int DW       = DW_DEFAULT,
  parameter int HYST_RST = HYST_DEFAULT
) (
  input  logic          i_wb_clk,
  input  logic          reset,
  input  logic          i_smp_valid,
  input  logic [2:0]    i_smp_ch,
  input  logic [DW-1:0] i_smp_data,
  input  logic [31:0]   i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic          o_irq
);

  localparam int         CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [3:0] NCH_W = 4'(NCH);

  // Stage 0 sample registers
  logic           smp_valid_q, smp_valid_d;
  logic [CHW-1:0] smp_ch_q, smp_ch_d;
  logic [DW-1:0]  smp_data_q, smp_data_d;

  // Per-channel state and control registers
  logic [DW-1:0]  stored_q [NCH];
  logic [DW-1:0]  stored_d [NCH];
  logic [NCH-1:0] seen_q, seen_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] irq_en_q, irq_en_d;
  logic [DW-1:0]  thresh_q, thresh_d;

  // Bus-side registers
  logic           ack_q, ack_d;
  logic [31:0]    rdt_q, rdt_d;
  logic           irq_q, irq_d;

  logic           cmp_gt, upd;
  logic [NCH-1:0] upd_vec, rd_clr, w1c;
  logic [3:0]     wb_idx;
  logic           bus_fire, wr_fire, rd_fire;
  logic           unused_bits;

  assign unused_bits = ^{i_wb_adr[31:6], i_wb_adr[1:0], i_wb_dat[31:DW]};

  // Stage 0 capture; out-of-range channels never enter the pipeline
  always_comb begin
    smp_valid_d = i_smp_valid && ({1'b0, i_smp_ch} < NCH_W);
    smp_ch_d    = i_smp_ch[CHW-1:0];
    smp_data_d  = i_smp_data;
  end

  rocketcpu_knob_cmp #(.DW(DW)) u_cmp (
    .i_new    (smp_data_q),
    .i_old    (stored_q[smp_ch_q]),
    .i_thresh (thresh_q),
    .o_update (cmp_gt)
  );

  // A channel's first sample after reset always lands, whatever the threshold
  assign upd = smp_valid_q && (!seen_q[smp_ch_q] || cmp_gt);

  // A transfer is accepted on any cycle with cyc high and no ack outstanding,
  // which naturally spaces back-to-back transfers two cycles apart
  assign wb_idx   = i_wb_adr[5:2];
  assign bus_fire = i_wb_cyc && !ack_q;
  assign wr_fire  = bus_fire && i_wb_we;
  assign rd_fire  = bus_fire && !i_wb_we;
  assign w1c      = (wr_fire && wb_idx == REG_PEND) ? i_wb_dat[NCH-1:0] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign upd_vec[gi] = upd && (smp_ch_q == CHW'(gi));
      assign rd_clr[gi]  = rd_fire && (wb_idx == REG_VAL0 + 4'(gi));
    end
  endgenerate

  // Channel state next-values; a set from the sample path beats any clear
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      stored_d[i] = upd_vec[i] ? smp_data_q : stored_q[i];
    end
    seen_d   = seen_q | upd_vec;
    pend_d   = (pend_q & ~(w1c | rd_clr)) | upd_vec;
    irq_en_d = (wr_fire && wb_idx == REG_IRQEN)  ? i_wb_dat[NCH-1:0] : irq_en_q;
    thresh_d = (wr_fire && wb_idx == REG_THRESH) ? i_wb_dat[DW-1:0]  : thresh_q;
    irq_d    = |(pend_q & irq_en_q);
  end

  // Read mux; data is captured from pre-update state so it lines up with ack
  always_comb begin
    ack_d = bus_fire;
    rdt_d = '0;
    if (rd_fire) begin
      if (wb_idx < REG_VAL0 + NCH_W)  rdt_d[DW-1:0]  = stored_q[wb_idx[CHW-1:0]];
      else if (wb_idx == REG_PEND)    rdt_d[NCH-1:0] = pend_q;
      else if (wb_idx == REG_IRQEN)   rdt_d[NCH-1:0] = irq_en_q;
      else if (wb_idx == REG_THRESH)  rdt_d[DW-1:0]  = thresh_q;
    end
  end

  // State registers; reset drops in-flight samples and transfers
  always_ff @(posedge i_wb_clk) begin
    if (reset) begin
      smp_valid_q <= 1'b0;
      smp_ch_q    <= '0;
      smp_data_q  <= '0;
      for (int i = 0; i < NCH; i++) stored_q[i] <= '0;
      seen_q      <= '0;
      pend_q      <= '0;
      irq_en_q    <= '0;
      thresh_q    <= DW'(HYST_RST);
      ack_q       <= 1'b0;
      rdt_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      smp_valid_q <= smp_valid_d;
      smp_ch_q    <= smp_ch_d;
      smp_data_q  <= smp_data_d;
      stored_q    <= stored_d;
      seen_q      <= seen_d;
      pend_q      <= pend_d;
      irq_en_q    <= irq_en_d;
      thresh_q    <= thresh_d;
      ack_q       <= ack_d;
      rdt_q       <= rdt_d;
      irq_q       <= irq_d;
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign o_irq    = irq_q;

endmodule
